// File: rtl/clkdiv_pkg.sv
// Purpose: shared types and constants for the programmable clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (IDLE/RUN) and DIV_MIN, the smallest divisor the block stores.
package clkdiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A requested divisor of 0 is stored as this value.
  localparam int DIV_MIN = 1;

endpackage

// File: rtl/dff_sync.sv
// Purpose: D flip-flop with synchronous active-high reset, used for registered outputs.
// Latency: 1 cycle from d to q.
// Backpressure: none.
// Ports: clock (rising edge), reset (sync, active-high, clears q), d (data in), q (data out).
module dff_sync #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/clock_divider_prog.sv
// Purpose: programmable tick divider; one-cycle tick on clock_out every N enabled cycles.
// Latency: tick is registered one cycle after the terminal count; the first tick comes N+1 cycles after enable rises.
// Backpressure: div_ready drops while a new divisor is waiting; the divisor is applied at the next wrap, or at once when idle.
// Ports: clock, reset (sync, active-high), enable, div_in/div_valid/div_ready (divisor handshake),
//        clock_out (tick), count (counter Q), sq_out (square wave).
// Build option: define CLKDIV_SQUARE_EN to generate sq_out; otherwise sq_out is tied to 0.
module clock_divider_prog #(
  parameter int WIDTH     = 9,
  parameter int DIV_RESET = 500
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clock_out,
  output logic [WIDTH-1:0] count,
  output logic             sq_out
);
  import clkdiv_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic             run;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_div;
  logic             pending;
  logic             terminal;
  logic             transfer;
  logic             apply;
  logic [WIDTH-1:0] div_cap;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run = 1'b0;
    case (state)
      RUN:     run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  // ---------------- counter and divisor reload ----------------
  assign terminal  = run && (q == (div_q - WIDTH'(1)));
  assign div_ready = !pending;
  assign transfer  = div_valid && !pending;
  // Reload only at a wrap, so a running period is never shortened or stretched;
  // while idle Q is already 0, so the reload can land immediately.
  assign apply     = pending && (terminal || !run);
  assign div_cap   = (div_in == '0) ? WIDTH'(DIV_MIN) : div_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      q        <= '0;
      div_q    <= WIDTH'(DIV_RESET);
      pend_div <= '0;
      pending  <= 1'b0;
    end else begin
      if (!run || terminal) q <= '0;
      else                  q <= q + WIDTH'(1);

      if (apply) begin
        div_q   <= pend_div;
        pending <= 1'b0;
      end
      // transfer needs !pending and apply needs pending, so they never collide;
      // a transfer on a terminal-count cycle waits for the following wrap.
      if (transfer) begin
        pend_div <= div_cap;
        pending  <= 1'b1;
      end
    end
  end

  assign count = q;

  // ---------------- registered outputs ----------------
  dff_sync #(.W(1)) u_tick (
    .clock (clock),
    .reset (reset),
    .d     (terminal),
    .q     (clock_out)
  );

`ifdef CLKDIV_SQUARE_EN
  logic [WIDTH-1:0] half;
  logic             sq_d;

  // ceil(div_q/2): odd divisors keep the output high one extra cycle.
  assign half = (div_q >> 1) + {{(WIDTH-1){1'b0}}, div_q[0]};
  assign sq_d = run && (q < half);

  dff_sync #(.W(1)) u_sq (
    .clock (clock),
    .reset (reset),
    .d     (sq_d),
    .q     (sq_out)
  );
`else
  assign sq_out = 1'b0;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
module tb_clock_divider_prog;
  localparam int WIDTH     = 9;
  localparam int DIV_RESET = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             div_valid = 1'b0;
  logic             div_ready;
  logic             clock_out;
  logic [WIDTH-1:0] count;
  logic             sq_out;

  clock_divider_prog #(.WIDTH(WIDTH), .DIV_RESET(DIV_RESET)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clock_out (clock_out),
    .count     (count),
    .sq_out    (sq_out)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int prev_tick = 0;
  int last_gap = 0;
  int t0;

  // Reference model: a running flag, the phase within the current period,
  // the active divisor and a queue holding at most one waiting divisor.
  bit m_run = 0;
  int m_ph = 0;
  int m_n = DIV_RESET;
  int m_pend[$];
  bit m_tick = 0;
  bit m_sq = 0;

  typedef struct {
    bit rst;
    bit en;
    bit vld;
    int din;
    int e_cnt;
    int e_tick;
    int e_rdy;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (reset) begin
      m_run = 0; m_ph = 0; m_n = DIV_RESET; m_pend.delete(); m_tick = 0; m_sq = 0;
    end else begin
      acc    = div_valid && (m_pend.size() == 0);
      m_sq   = m_run && (m_ph < (m_n + 1) / 2);
      m_tick = m_run && (m_ph == m_n - 1);
      if (m_run && (m_ph != m_n - 1)) begin
        m_ph++;
      end else begin
        m_ph = 0;
        if (m_pend.size() > 0) m_n = m_pend.pop_front();
      end
      if (acc) m_pend.push_back((div_in == 0) ? 1 : int'(div_in));
      m_run = enable;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    cyc++;
    if (clock_out) begin
      last_gap  = cyc - prev_tick;
      prev_tick = cyc;
    end
    chk("count", int'(count), m_ph);
    chk("clock_out", int'(clock_out), int'(m_tick));
    chk("div_ready", int'(div_ready), int'(m_pend.size() == 0));
`ifdef CLKDIV_SQUARE_EN
    chk("sq_out", int'(sq_out), int'(m_sq));
`else
    chk("sq_out_tied", int'(sq_out), 0);
`endif
  endtask

  task automatic wait_tick(input int bound);
    int n;
    step();
    n = 1;
    while (!clock_out && n < bound) begin
      step();
      n++;
    end
    if (!clock_out) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: no clock_out within %0d cycles (cycle %0d)", bound, cyc);
    end
  endtask

  task automatic offer(input int d);
    div_valid = 1'b1;
    div_in    = WIDTH'(d);
    step();
    div_valid = 1'b0;
  endtask

  initial begin
    // rst en vld din | count tick ready ; divisor offered during reset is dropped
    tbl[0] = '{1, 0, 1, 7, 0, 0, 1};
    tbl[1] = '{0, 1, 0, 0, 0, 0, 1};
    tbl[2] = '{0, 1, 0, 0, 1, 0, 1};
    tbl[3] = '{0, 1, 0, 0, 2, 0, 1};
    tbl[4] = '{0, 1, 0, 0, 3, 0, 1};
    tbl[5] = '{0, 1, 0, 0, 0, 1, 1};
    tbl[6] = '{0, 1, 0, 0, 1, 0, 1};
    tbl[7] = '{0, 1, 0, 0, 2, 0, 1};
    tbl[8] = '{0, 1, 0, 0, 3, 0, 1};
    tbl[9] = '{0, 1, 0, 0, 0, 1, 1};

    for (int i = 0; i < 10; i++) begin
      reset     = tbl[i].rst;
      enable    = tbl[i].en;
      div_valid = tbl[i].vld;
      div_in    = WIDTH'(tbl[i].din);
      step();
      chk("tbl_count", int'(count), tbl[i].e_cnt);
      chk("tbl_tick", int'(clock_out), tbl[i].e_tick);
      chk("tbl_ready", int'(div_ready), tbl[i].e_rdy);
    end
    div_valid = 1'b0;

    // Mid-period reload to 6: current period stays 4, then 6.
    step();
    offer(6);
    chk("reload_busy", int'(div_ready), 0);
    wait_tick(20);
    chk("reload_gap_old", last_gap, 4);
    chk("reload_ready_back", int'(div_ready), 1);
    wait_tick(20);
    chk("reload_gap_new_a", last_gap, 6);
    wait_tick(20);
    chk("reload_gap_new_b", last_gap, 6);

    // Back to 4, then a transfer coincident with the terminal count.
    offer(4);
    wait_tick(20);
    chk("back4_gap_6", last_gap, 6);
    wait_tick(20);
    chk("back4_gap_4", last_gap, 4);
    step(); step(); step();
    chk("at_terminal_count", int'(count), 3);
    offer(2);
    chk("coincident_tick", int'(clock_out), 1);
    chk("coincident_busy", int'(div_ready), 0);
    wait_tick(20);
    chk("coincident_gap_4", last_gap, 4);
    wait_tick(20);
    chk("coincident_gap_2a", last_gap, 2);
    wait_tick(20);
    chk("coincident_gap_2b", last_gap, 2);

    // Divisor 0 behaves as 1: tick every cycle, count pinned at 0.
    offer(0);
    wait_tick(20);
    chk("zero_gap_2", last_gap, 2);
    wait_tick(20);
    chk("zero_gap_1a", last_gap, 1);
    wait_tick(20);
    chk("zero_gap_1b", last_gap, 1);
    chk("zero_count", int'(count), 0);

    // Restore 4, then drop enable at Q=2 for 3 cycles.
    offer(4);
    wait_tick(20);
    chk("restore_gap_1", last_gap, 1);
    wait_tick(20);
    chk("restore_gap_4", last_gap, 4);
    step(); step();
    chk("pre_idle_count", int'(count), 2);
    enable = 1'b0;
    step(); step(); step();
    chk("idle_count", int'(count), 0);
    chk("idle_tick", int'(clock_out), 0);
    enable = 1'b1;
    t0 = cyc;
    wait_tick(20);
    chk("reenable_latency", cyc - t0, 5);

    // Reset mid-period restores DIV_RESET.
    offer(7);
    wait_tick(20);
    step(); step();
    chk("pre_reset_count", int'(count), 2);
    reset = 1'b1;
    step();
    chk("rst_count", int'(count), 0);
    chk("rst_tick", int'(clock_out), 0);
    chk("rst_sq", int'(sq_out), 0);
    chk("rst_ready", int'(div_ready), 1);
    reset = 1'b0;
    t0 = cyc;
    wait_tick(20);
    chk("post_reset_latency", cyc - t0, 5);
    wait_tick(20);
    chk("post_reset_gap", last_gap, 4);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      div_valid = ($urandom_range(0, 7) == 0);
      div_in    = ($urandom_range(0, 15) == 0) ? WIDTH'(511) : WIDTH'($urandom_range(0, 9));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
CLOCK_DIVIDER_PROG -- requirements
Module: clock_divider_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 9, counter and divisor width in bits.
REQ-002 SHALL have parameter DIV_RESET, default 500, divisor loaded at reset; range 1..2^WIDTH-1.
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  run request; low holds block idle.
REQ-006 SHALL have port div_in  input  WIDTH  new divisor value N.
REQ-007 SHALL have port div_valid  input  1  div_in offered this cycle.
REQ-008 SHALL have port div_ready  output  1  block can accept a divisor this cycle.
REQ-009 SHALL have port clock_out  output  1  registered one-cycle tick, once per N enabled cycles.
REQ-010 SHALL have port count  output  WIDTH  current counter value Q.
REQ-011 SHALL have port sq_out  output  1  registered square-wave output (see Configuration).

Function
REQ-012 SHALL implement two states: IDLE (enable=0) and RUN (enable=1); IDLE->RUN when enable=1, RUN->IDLE when enable=0, evaluated every cycle.
REQ-013 In IDLE, Q SHALL be forced to 0 and clock_out SHALL be 0 the following cycle.
REQ-014 In RUN, Q SHALL increment by 1 per cycle and wrap to 0 on terminal count (Q == div_q-1).
REQ-015 clock_out SHALL be 1 exactly in the cycle after a terminal count: one-cycle latency, one-cycle width.
REQ-016 After IDLE->RUN, the first clock_out SHALL occur N+1 cycles after the first cycle with enable=1 (terminal count at enable-cycle N, tick registered one cycle later); thereafter, period SHALL be exactly N cycles.
REQ-017 A captured divisor of 0 SHALL be stored as 1; N=1 SHALL produce clock_out high every cycle while in RUN (after first-tick latency).
REQ-018 div_ready SHALL be 1 whenever no reload is pending; a transfer occurs when div_valid and div_ready are both 1.
REQ-019 A transfer SHALL store div_in in pend_div and set pending; div_ready SHALL be 0 while pending.
REQ-020 A pending divisor SHALL be applied at the next terminal count in RUN (Q->0, div_q<=pend_div, pending cleared), or on the next cycle if in IDLE.
REQ-021 Transfer in the same cycle as a terminal count SHALL NOT affect the current wrap; the value applies at the following terminal count.
REQ-022 Counter arithmetic SHALL be unsigned WIDTH-bit; Q SHALL never exceed div_q-1.
REQ-023 Dropping enable mid-period SHALL discard the partial period and preserve any pending divisor.

Reset
REQ-024 On reset=1 at a rising edge: Q=0, div_q=DIV_RESET, pending=0, state=IDLE, clock_out=0, sq_out=0, div_ready=1 the next cycle.
REQ-025 Reset SHALL override enable and any handshake in the same cycle; a divisor offered during reset SHALL be dropped.

Configuration
REQ-026 Macro CLKDIV_SQUARE_EN defined: sq_out SHALL be registered 1 while Q < ceil(div_q/2) in RUN, else 0; duty is 50% for even N and high one extra cycle for odd N; N=1 gives constant 1.
REQ-027 Macro CLKDIV_SQUARE_EN undefined: sq_out SHALL be tied 0 and no comparator logic SHALL be synthesised.

Structure
REQ-028 Package clkdiv_pkg SHALL hold the state typedef (IDLE, RUN) and constant DIV_MIN=1.
REQ-029 Output registers (clock_out, sq_out) SHALL use sub-module dff_sync: a synchronous-reset D flip-flop.

Verification
REQ-030 WIDTH=9, DIV_RESET=4, reset, enable=1 -> first clock_out 5 cycles after the first enabled edge, then every 4 cycles; count sequence 0,1,2,3,0.
REQ-031 Running N=4, div_in=6 accepted mid-period -> div_ready=0, next period still 4, subsequent periods 6, div_ready returns 1 at the wrap.
REQ-032 Transfer coincident with the terminal count (Q=3, N=4), div_in=2 -> one more 4-cycle period, then 2-cycle periods.
REQ-033 div_in=0 accepted -> clock_out high every cycle in RUN; count stays 0.
REQ-034 enable low at Q=2, then high after 3 cycles -> count 0 while idle, and the next tick occurs 5 cycles after re-enable; reset asserted mid-period -> all outputs 0 and div_q=4 the next cycle.
REQ-035 CLKDIV_SQUARE_EN defined with N=5 -> sq_out high 3 cycles, low 2 cycles, repeating; undefined -> sq_out constant 0.
